// File: rtl/simple_proc_instr_sequencer_if.sv
// Host write channel and processor Run/DIN/Done channel.
// master = host/processor side, slave = sequencer side.
interface simple_proc_instr_sequencer_if;
  logic       wr_valid;
  logic [8:0] wr_data;
  logic       wr_ready;
  logic       Run;
  logic [8:0] DIN;
  logic       Done;

  modport master (
    output wr_valid, wr_data, Done,
    input  wr_ready, Run, DIN
  );

  modport slave (
    input  wr_valid, wr_data, Done,
    output wr_ready, Run, DIN
  );
endinterface

// File: rtl/simple_proc_instr_sequencer.sv
// Queue-fed instruction sequencer for the 9-bit simple processor.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module simple_proc_instr_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [2:0]  MVI_OPCODE = 3'b011,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     enable,
  simple_proc_instr_sequencer_if.slave bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              retired_count,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    IMM,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [AW:0]   count;
  logic          full, push, pop;
  logic [8:0]    head, head2;
  logic          head_mvi, can_issue;
  logic          retire;
  logic          run_q, run_d;
  logic [8:0]    din_q, din_d;

  assign full      = (count == (AW+1)'(DEPTH));
  assign push      = bus.wr_valid && !full;
  assign rd_nxt    = rd_ptr + 1'b1;
  assign head      = mem[rd_ptr];
  assign head2     = mem[rd_nxt];
  assign head_mvi  = (head[8:6] == MVI_OPCODE);
  // an mvi is only started once its immediate is already queued
  assign can_issue = enable && (count != '0)
                   && (!head_mvi || count >= (AW+1)'(2));

  assign bus.wr_ready = !full;
  assign bus.Run      = run_q;
  assign bus.DIN      = din_q;
  assign fifo_count   = count;

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       wd_hit, to_fire, to_q;

  assign wd_hit  = (wd_q == 8'(TIMEOUT - 1)) && !bus.Done;
  assign timeout = to_q;

  // watchdog: restart on issue, count Done-less cycles in IMM/WAIT
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)
        wd_q <= '0;
      else if ((state_q == IMM || state_q == WAIT) && !bus.Done)
        wd_q <= wd_q + 8'd1;
      if (to_fire)
        to_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // queue storage; contents need no reset, pointers define validity
  always_ff @(posedge Clock) begin
    if (push)
      mem[wr_ptr] <= bus.wr_data;
  end

  // queue pointers and occupancy
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // next state, queue pop and retire strobe
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    retire  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    to_fire = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (can_issue)
          state_d = ISSUE;
      end
      ISSUE: begin
        pop     = 1'b1;
        state_d = head_mvi ? IMM : WAIT;
      end
      IMM: begin
        if (bus.Done) begin
          pop     = 1'b1;
          retire  = 1'b1;
          state_d = IDLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          pop     = 1'b1;
          to_fire = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      WAIT: begin
        if (bus.Done) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          to_fire = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // registered Run/DIN follow the state being entered
  always_comb begin
    run_d = 1'b0;
    din_d = '0;
    unique case (1'b1)
      (state_d == ISSUE): begin
        run_d = 1'b1;
        din_d = head;
      end
      (state_d == IMM): begin
        din_d = (state_q == ISSUE) ? head2 : din_q;
      end
      default: begin
        din_d = '0;
      end
    endcase
  end

  // state and registered processor-facing outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      din_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      din_q   <= din_d;
      busy    <= (state_d != IDLE);
    end
  end

  // retired instruction counter, wraps naturally
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      retired_count <= '0;
    else if (retire)
      retired_count <= retired_count + 16'd1;
  end

endmodule

// File: tb/tb_simple_proc_instr_sequencer.sv
// Bench for simple_proc_instr_sequencer.
// Queue/instruction model plus directed vectors.
module tb_simple_proc_instr_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam logic [2:0] MVI = 3'b011;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] retired_count;
  logic        timeout;

  simple_proc_instr_sequencer_if sif();

  simple_proc_instr_sequencer #(
    .DEPTH(DEPTH),
    .MVI_OPCODE(MVI),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock(clk),
    .Resetn(rst_n),
    .enable(enable),
    .bus(sif),
    .busy(busy),
    .fifo_count(fifo_count),
    .retired_count(retired_count),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // model: queue of unpopped words plus the instruction in flight
  logic [8:0] mq[$];
  bit         m_inf;
  int         m_age;
  logic [8:0] m_w0, m_imm, m_h, m_pdat;
  bit         m_mvi, m_push, m_to;
  int         m_wd;
  int         m_ret;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_inf = 0;
      m_age = 0;
      m_wd  = 0;
      m_ret = 0;
      m_to  = 0;
      m_mvi = 0;
      m_w0  = '0;
      m_imm = '0;
    end else begin
      m_push = sif.wr_valid && (mq.size() < DEPTH);
      m_pdat = sif.wr_data;
      if (!m_inf) begin
        if (enable && mq.size() > 0) begin
          m_h = mq[0];
          if (m_h[8:6] != MVI || mq.size() >= 2) begin
            m_inf = 1;
            m_age = 0;
            m_w0  = m_h;
            m_mvi = (m_h[8:6] == MVI);
            m_imm = m_mvi ? mq[1] : 9'd0;
          end
        end
      end else if (m_age == 0) begin
        void'(mq.pop_front());
        m_age = 1;
        m_wd  = 0;
      end else if (sif.Done) begin
        m_ret = (m_ret + 1) % 65536;
        if (m_mvi) void'(mq.pop_front());
        m_inf = 0;
      end else begin
`ifdef SEQ_TIMEOUT_EN
        m_wd++;
        if (m_wd == TIMEOUT) begin
          m_to = 1;
          if (m_mvi) void'(mq.pop_front());
          m_inf = 0;
        end
`endif
      end
      if (m_push) mq.push_back(m_pdat);
    end
  end

  logic [8:0] e_din;

  // compare DUT to model every cycle
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      if (!m_inf)          e_din = '0;
      else if (m_age == 0) e_din = m_w0;
      else if (m_mvi)      e_din = m_imm;
      else                 e_din = '0;
      chk("run", sif.Run, (m_inf && m_age == 0));
      chk("din", sif.DIN, e_din);
      chk("busy", busy, m_inf);
      chk("fifo_count", fifo_count, mq.size());
      chk("wr_ready", sif.wr_ready, (mq.size() < DEPTH));
      chk("retired", retired_count, m_ret);
      chk("timeout", timeout, m_to);
    end
  end

  task automatic push(input logic [8:0] w);
    @(posedge clk); #1;
    sif.wr_valid = 1'b1;
    sif.wr_data  = w;
    @(posedge clk); #1;
    sif.wr_valid = 1'b0;
  endtask

  task automatic done_pulse();
    @(posedge clk); #1;
    sif.Done = 1'b1;
    @(posedge clk); #1;
    sif.Done = 1'b0;
  endtask

  task automatic wait_run(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sif.Run && n < lim);
    chk("wait_run", sif.Run, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  int norun;
  int ncyc;

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    sif.wr_valid = 1'b0;
    sif.wr_data  = '0;
    sif.Done     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_run", sif.Run, 1'b0);
    chk("rst_din", sif.DIN, 9'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo", fifo_count, 4'd0);
    chk("rst_wr_ready", sif.wr_ready, 1'b1);
    chk("rst_retired", retired_count, 16'd0);
    chk("rst_timeout", timeout, 1'b0);
    rst_n  = 1'b1;
    chk_on = 1;

    // mvi then mv queued behind it
    push(9'o301);
    push(9'o717);
    enable = 1'b1;
    wait_run(20);
    chk("t2_din_op", sif.DIN, 9'o301);
    @(negedge clk);
    chk("t2_din_imm", sif.DIN, 9'o717);
    push(9'o052);
    @(negedge clk);
    chk("t2_imm_held", sif.DIN, 9'o717);
    done_pulse();
    @(negedge clk);
    chk("t3_gap_run", sif.Run, 1'b0);
    chk("t2_retired", retired_count, 16'd1);
    @(negedge clk);
    chk("t3_run", sif.Run, 1'b1);
    chk("t3_din_op", sif.DIN, 9'o052);
    @(negedge clk);
    chk("t3_din_wait", sif.DIN, 9'd0);
    chk("t3_busy", busy, 1'b1);
    done_pulse();
    @(negedge clk);
    chk("t3_retired", retired_count, 16'd2);

    // split mvi must not start
    push(9'o321);
    norun = 0;
    repeat (10) begin
      @(negedge clk);
      if (sif.Run) norun++;
    end
    chk("t4_no_run", norun, 0);
    push(9'o777);
    wait_run(5);
    chk("t4_din_op", sif.DIN, 9'o321);
    @(negedge clk);
    chk("t4_din_imm", sif.DIN, 9'o777);
    done_pulse();
    @(negedge clk);
    chk("t4_retired", retired_count, 16'd3);

    // fill the queue with enable low, ninth push dropped
    enable = 1'b0;
    @(posedge clk); #1;
    sif.wr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sif.wr_data = {3'b001, 6'(i * 5)};
      @(posedge clk); #1;
    end
    sif.wr_valid = 1'b0;
    @(negedge clk);
    chk("t5_full_count", fifo_count, 4'd8);
    chk("t5_wr_ready", sif.wr_ready, 1'b0);
    sif.wr_valid = 1'b1;
    sif.wr_data  = 9'o444;
    enable       = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sif.wr_valid = 1'b0;
    done_pulse();
    repeat (8) begin
      wait_run(10);
      done_pulse();
    end
    @(negedge clk);
    chk("t5_drained", fifo_count, 4'd0);
    chk("t5_idle", busy, 1'b0);
    chk("t5_retired", retired_count, 16'd12);

`ifdef SEQ_TIMEOUT_EN
    push(9'o052);
    wait_run(10);
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (!timeout && ncyc < 40);
    chk("t6_timeout", timeout, 1'b1);
    chk("t6_cycles", ncyc, 17);
    chk("t6_busy", busy, 1'b0);
    chk("t6_retired", retired_count, 16'd12);
    push(9'o063);
    wait_run(10);
    chk("t6_next_din", sif.DIN, 9'o063);
    done_pulse();
    @(negedge clk);
    chk("t6_sticky", timeout, 1'b1);
`else
    ncyc = 0;
`endif

    // async reset in the middle of an mvi immediate phase
    push(9'o301);
    push(9'o717);
    wait_run(10);
    @(negedge clk);
    chk("t1_in_imm", sif.DIN, 9'o717);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_run", sif.Run, 1'b0);
    chk("t1_din", sif.DIN, 9'd0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_fifo", fifo_count, 4'd0);
    chk("t1_wr_ready", sif.wr_ready, 1'b1);
    chk("t1_retired", retired_count, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_after_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
